execute_stage_mc: RTL
=====================

# execute_stage_mc

Parametrised EX stage for the RV32I pipeline: XLEN-wide ALU with full RV32I branch comparisons, JAL/JALR target generation, 3-input operand forwarding, and a multi-cycle multiplier that stalls the front end. It sits between the ID/EX register and the MEM stage, and owns the EX/MEM pipeline register. The hazard unit consumes `StallE_o`; branch resolution drives `PCSrcE`/`PCTargetE` to fetch.

## Interface
- `XLEN`, 32: datapath width.
- `REG_AW`, 5: register address width.
- `MUL_CYCLES`, 4: cycles a MUL occupies EX; must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `FlushE` in 1: kill the instruction in EX (synchronous).
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `JalrE`, `ALUSrcE` in 1 each: decoded controls.
- `ResultSrcE` in 2: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE` in 4: ALU operation.
- `BranchTypeE` in 3: funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- `RD1_E`, `RD2_E`, `Imm_Ext_E`, `PCE`, `PCPlus4E` in XLEN each.
- `RD_E` in REG_AW.
- `ResultW` in XLEN: WB forwarding source.
- `ForwardA_E`, `ForwardB_E` in 2: 00 register, 01 ResultW, 10 ALU_ResultM, 11 treated as 00.
- `PCSrcE` out 1; `PCTargetE` out XLEN.
- `StallE_o` out 1: freeze IF/ID and ID/EX.
- `RegWriteM`, `MemWriteM` out 1; `ResultSrcM` out 2; `RD_M` out REG_AW.
- `PCPlus4M`, `WriteDataM`, `ALU_ResultM` out XLEN.

## Operation
- SrcA = fwd mux A. SrcB_pre = fwd mux B. SrcB = ALUSrcE ? Imm_Ext_E : SrcB_pre. WriteData = SrcB_pre.
- ALUControlE: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low XLEN bits of product). Other codes produce 0. Shift amount = SrcB[$clog2(XLEN)-1:0]. All arithmetic wraps modulo 2^XLEN.
- Branch condition from SrcA/SrcB_pre per BranchTypeE; undefined funct3 = not taken.
- PCSrcE = (BranchE & cond) | JumpE. Gated to 0 when FlushE=1.
- PCTargetE = JalrE ? (SrcA + Imm_Ext_E) & ~1 : PCE + Imm_Ext_E.
- MUL FSM states:
  - IDLE: a MUL in EX with FlushE=0 latches SrcA/SrcB, loads the counter with MUL_CYCLES-2, asserts StallE_o, and moves to BUSY. The EX/MEM register takes a bubble.
  - BUSY with counter ≠ 0: StallE_o=1, decrement, bubble into EX/MEM.
  - BUSY with counter = 0: StallE_o=0. EX/MEM captures the product from the latched operands plus the MUL's controls. Return to IDLE.
  - The product must use only the latched operands. Forward inputs may change during BUSY.
  - Iterative or pipelined multiply is permitted.
- Bubble = RegWriteM=0, MemWriteM=0, ResultSrcM=00, RD_M=0; data fields don't-care (drive 0).
- Non-MUL ops never stall; EX/MEM captures every cycle.
- FlushE=1: EX/MEM takes a bubble, FSM goes to IDLE, StallE_o=0 the same cycle. Flush aborts an in-progress MUL.
- Priority: rst > FlushE > FSM.

## Timing
- Reset: state IDLE, counter 0, StallE_o=0, all EX/MEM outputs 0.
- Non-MUL latency: 1 cycle EX→M.
- MUL occupies EX for exactly MUL_CYCLES cycles. StallE_o is high for the first MUL_CYCLES-1 of them, combinationally, from the first cycle. The result appears on ALU_ResultM after the edge ending cycle MUL_CYCLES.
- Back-to-back MULs: the second enters the cycle after the first releases and starts from IDLE again, with no idle gap.
- PCSrcE/PCTargetE are combinational; ALU branches are never MUL, so they never overlap a stall.
- rst mid-MUL: abort, IDLE next cycle, no result written.

## Test plan
- ADD, RD1_E=5, ForwardB=10 with ALU_ResultM=7 → ALU_ResultM=12 next cycle; ForwardA=01 with ResultW=0x100 selects 0x100.
- BLT, SrcA=0xFFFFFFFF, SrcB=1 → PCSrcE=1. BLTU with the same operands → PCSrcE=0. BEQ with equal operands → PCSrcE=1.
- JALR, SrcA=0x1001, Imm=4 → PCTargetE=0x1004, PCSrcE=1. ResultSrcE=10 carries PCPlus4M through.
- MUL 7×(−3), MUL_CYCLES=4 → StallE_o=1,1,1,0; three bubbles (RegWriteM=0); then ALU_ResultM=0xFFFFFFEB, RegWriteM=1. Forward inputs changed mid-op must not affect the result.
- FlushE asserted in the 2nd MUL cycle → StallE_o=0 that cycle, bubble in EX/MEM, no product written. A following ADD proceeds normally.
- rst pulsed mid-MUL → all outputs 0 next cycle. A new MUL afterwards completes correctly in MUL_CYCLES.

Source files
------------

// File: rtl/execute_stage_mc.sv
// RV32I execute stage: ALU, branch/jump resolution, operand forwarding,
// multi-cycle MUL with front-end stall, and the EX/MEM pipeline register.
module execute_stage_mc #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FlushE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              BranchE,
    input  logic              JumpE,
    input  logic              JalrE,
    input  logic              ALUSrcE,
    input  logic [1:0]        ResultSrcE,
    input  logic [3:0]        ALUControlE,
    input  logic [2:0]        BranchTypeE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              StallE_o,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   ALU_ResultM
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic [XLEN-1:0]   r_mul_a, r_mul_b;
    logic              w_stall, w_start, w_capture, w_is_mul, w_cond;
    logic [XLEN-1:0]   w_srcA, w_srcB_pre, w_srcB, w_alu, w_prod, w_jalr_t;
    logic [SHW-1:0]    w_shamt;

    logic              r_regwrite, r_memwrite;
    logic [1:0]        r_resultsrc;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_pcplus4, r_wdata, r_alu;

    assign w_is_mul   = (ALUControlE == 4'b1010);
    assign w_srcB     = ALUSrcE ? Imm_Ext_E : w_srcB_pre;
    assign w_shamt    = w_srcB[SHW-1:0];
    assign w_prod     = r_mul_a * r_mul_b;
    assign w_jalr_t   = w_srcA + Imm_Ext_E;

    // Forwarding muxes; code 11 falls back to the register value
    always_comb begin
        case (ForwardA_E)
            2'b01:   w_srcA = ResultW;
            2'b10:   w_srcA = r_alu;
            default: w_srcA = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   w_srcB_pre = ResultW;
            2'b10:   w_srcB_pre = r_alu;
            default: w_srcB_pre = RD2_E;
        endcase
    end

    // ALU; MUL result comes from the operands latched at MUL start
    always_comb begin
        case (ALUControlE)
            4'b0000: w_alu = w_srcA + w_srcB;
            4'b0001: w_alu = w_srcA - w_srcB;
            4'b0010: w_alu = w_srcA & w_srcB;
            4'b0011: w_alu = w_srcA | w_srcB;
            4'b0100: w_alu = w_srcA ^ w_srcB;
            4'b0101: w_alu = {{(XLEN-1){1'b0}},
                              $signed(w_srcA) < $signed(w_srcB)};
            4'b0110: w_alu = {{(XLEN-1){1'b0}}, w_srcA < w_srcB};
            4'b0111: w_alu = w_srcA << w_shamt;
            4'b1000: w_alu = w_srcA >> w_shamt;
            4'b1001: w_alu = $unsigned($signed(w_srcA) >>> w_shamt);
            4'b1010: w_alu = w_prod;
            default: w_alu = '0;
        endcase
    end

    // Branch condition on the forwarded register operands
    always_comb begin
        case (BranchTypeE)
            3'b000:  w_cond = (w_srcA == w_srcB_pre);
            3'b001:  w_cond = (w_srcA != w_srcB_pre);
            3'b100:  w_cond = $signed(w_srcA) < $signed(w_srcB_pre);
            3'b101:  w_cond = $signed(w_srcA) >= $signed(w_srcB_pre);
            3'b110:  w_cond = w_srcA < w_srcB_pre;
            3'b111:  w_cond = w_srcA >= w_srcB_pre;
            default: w_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = ~FlushE & ((BranchE & w_cond) | JumpE);
    assign PCTargetE = JalrE ? {w_jalr_t[XLEN-1:1], 1'b0}
                             : PCE + Imm_Ext_E;
    assign StallE_o  = w_stall;

    // MUL sequencing: stall and bubble until the counter runs out
    always_comb begin
        w_next    = r_state;
        w_cnt_nx  = r_cnt;
        w_stall   = 1'b0;
        w_start   = 1'b0;
        w_capture = 1'b1;
        if (FlushE) begin
            w_next    = S_IDLE;
            w_cnt_nx  = '0;
            w_capture = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        w_start   = 1'b1;
                        w_stall   = 1'b1;
                        w_capture = 1'b0;
                        w_next    = S_BUSY;
                        w_cnt_nx  = CW'(MUL_CYCLES - 2);
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        w_stall   = 1'b1;
                        w_capture = 1'b0;
                        w_cnt_nx  = r_cnt - 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // FSM state and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Latch MUL operands so forwarding changes cannot disturb the product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_start) begin
            r_mul_a <= w_srcA;
            r_mul_b <= w_srcB;
        end
    end

    // EX/MEM pipeline register; bubble whenever no result is ready
    always_ff @(posedge clk) begin
        if (rst || !w_capture) begin
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_rd        <= '0;
            r_pcplus4   <= '0;
            r_wdata     <= '0;
            r_alu       <= '0;
        end else begin
            r_regwrite  <= RegWriteE;
            r_memwrite  <= MemWriteE;
            r_resultsrc <= ResultSrcE;
            r_rd        <= RD_E;
            r_pcplus4   <= PCPlus4E;
            r_wdata     <= w_srcB_pre;
            r_alu       <= w_alu;
        end
    end

    assign RegWriteM   = r_regwrite;
    assign MemWriteM   = r_memwrite;
    assign ResultSrcM  = r_resultsrc;
    assign RD_M        = r_rd;
    assign PCPlus4M    = r_pcplus4;
    assign WriteDataM  = r_wdata;
    assign ALU_ResultM = r_alu;

endmodule
